// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID buffer and MIPS field decoding.
package if_id_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JADDR_HI  = 25;
  localparam int JADDR_LO  = 0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side signals of the IF/ID buffer; the buffer takes the slave view.
interface if_id_buffer_if;

  logic [31:0] InPC;
  logic [31:0] InInstr;
  logic        InValid;
  logic        InReady;
  logic        Flush;
  logic [31:0] OutPC;
  logic [31:0] OutInstr;
  logic        OutValid;
  logic        OutReady;
  logic [5:0]  Opcode;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Shamt;
  logic [5:0]  Funct;
  logic [31:0] Imm;
  logic [25:0] JAddr;

  modport master (
    output InPC, InInstr, InValid, Flush, OutReady,
    input  InReady, OutPC, OutInstr, OutValid,
           Opcode, Rs, Rt, Rd, Shamt, Funct, Imm, JAddr
  );

  modport slave (
    input  InPC, InInstr, InValid, Flush, OutReady,
    output InReady, OutPC, OutInstr, OutValid,
           Opcode, Rs, Rt, Rd, Shamt, Funct, Imm, JAddr
  );

endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational MIPS R/I/J field slicer; usable by any stage holding an instruction word.
module instr_field_decode
  import if_id_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm,
  output logic [25:0] jaddr
);

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign shamt  = instr[SHAMT_HI:SHAMT_LO];
  assign funct  = instr[FUNCT_HI:FUNCT_LO];
  assign imm    = sign_ext16(instr[IMM_HI:IMM_LO]);
  assign jaddr  = instr[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer with flush and head-instruction field decode.
// Optional performance counters: define IF_ID_BUFFER_PERF_CNT_EN.
module if_id_buffer
  import if_id_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  if_id_buffer_if.slave bus
`ifdef IF_ID_BUFFER_PERF_CNT_EN
  ,
  output logic [31:0]   StallCount,
  output logic [31:0]   FlushCount
`endif
);

  occ_e   state, state_next;
  entry_t head, tail, incoming;
  logic   in_ready, out_valid, push, pop;
  logic   load_head_in, load_head_tail, load_tail;

  // Ready is a function of registered occupancy only, so fetch never waits on decode.
  assign in_ready  = (state != FULL) & ~bus.Flush & ~Rst;
  assign out_valid = (state != EMPTY) & ~bus.Flush;
  assign push      = bus.InValid & in_ready;
  assign pop       = out_valid & bus.OutReady;
  assign incoming  = '{pc: bus.InPC, instr: bus.InInstr};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (Rst || bus.Flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: unique case ({push, pop})
          2'b11: load_head_in = 1'b1;
          2'b10: begin
            state_next = FULL;
            load_tail  = 1'b1;
          end
          2'b01: state_next = EMPTY;
          default: state_next = ONE;
        endcase
        FULL: if (pop) begin
          state_next     = ONE;
          load_head_tail = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (Rst) state <= EMPTY;
    else     state <= state_next;
  end

  // NOTE: payload registers carry no reset; outputs are masked whenever the buffer is empty.
  always_ff @(posedge Clk) begin
    if (load_head_in)        head <= incoming;
    else if (load_head_tail) head <= tail;
    if (load_tail)           tail <= incoming;
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.OutPC    = out_valid ? head.pc    : 32'h0;
  assign bus.OutInstr = out_valid ? head.instr : NOP;

  instr_field_decode u_decode (
    .instr  (bus.OutInstr),
    .opcode (bus.Opcode),
    .rs     (bus.Rs),
    .rt     (bus.Rt),
    .rd     (bus.Rd),
    .shamt  (bus.Shamt),
    .funct  (bus.Funct),
    .imm    (bus.Imm),
    .jaddr  (bus.JAddr)
  );

`ifdef IF_ID_BUFFER_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCount <= 32'h0;
      FlushCount <= 32'h0;
    end else begin
      if (bus.InValid && !in_ready && !bus.Flush && StallCount != 32'hFFFF_FFFF)
        StallCount <= StallCount + 32'd1;
      if (bus.Flush && state != EMPTY && FlushCount != 32'hFFFF_FFFF)
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction-fetch-to-decode pipeline buffer: consumes the (PC, instruction) pair produced by the instruction fetch stage and presents it to the decode stage with a valid/ready handshake. A two-entry elastic buffer absorbs one cycle of decode back-pressure without losing a fetched word. Provides branch-flush support and slices the head instruction into MIPS R/I/J fields for the decode stage.

## Interface
- NOP, 32'h0000_0000, instruction value driven on OutInstr when no valid entry (sll $0,$0,0)
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- InPC  input  32  PC of fetched instruction
- InInstr  input  32  fetched instruction word
- InValid  input  1  fetch offers InPC/InInstr this cycle
- InReady  output  1  buffer can accept this cycle
- Flush  input  1  discard all buffered and incoming entries
- OutPC  output  32  PC of head entry
- OutInstr  output  32  instruction of head entry
- OutValid  output  1  head entry valid
- OutReady  input  1  decode consumes head this cycle
- Opcode  output  6  OutInstr[31:26]
- Rs, Rt, Rd  output  5 each  OutInstr[25:21], [20:16], [15:11]
- Shamt  output  5  OutInstr[10:6]
- Funct  output  6  OutInstr[5:0]
- Imm  output  32  sign-extended OutInstr[15:0]
- JAddr  output  26  OutInstr[25:0]

## Operation
- States by occupancy: EMPTY (0), ONE (1), FULL (2); entries held in order, head = oldest.
- Push = InValid & InReady; pop = OutValid & OutReady.
- InReady = (state != FULL) & !Flush & !Rst; depends only on registered state and Flush, never on OutReady.
- OutValid = (state != EMPTY) & !Flush.
- EMPTY: push -> ONE.
- ONE: push & pop -> ONE (new entry becomes head); push only -> FULL; pop only -> EMPTY.
- FULL: pop -> ONE (second entry becomes head); no push possible.
- Flush (priority below Rst, above all else): next state EMPTY; a word offered that cycle is not accepted; no pop occurs.
- When OutValid = 0: OutPC = 0, OutInstr = NOP; decoded fields therefore all zero.
- Field outputs are purely combinational slices of OutInstr; Imm replicates bit 15 into [31:16].

## Timing
- Rst asserted at a rising edge: next cycle state EMPTY, OutValid 0, OutPC 0, OutInstr NOP, InReady 0 while Rst held, 1 the first cycle after Rst drops.
- Rst mid-operation discards all entries, same as above.
- Latency: word pushed at edge N visible on OutPC/OutInstr with OutValid = 1 in cycle after edge N (1 cycle).
- Throughput: 1 word/cycle with OutReady held high; state oscillates EMPTY->ONE and stays ONE.
- OutReady low for k cycles with continuous InValid: at most 2 words accepted, InReady drops after second push, no word lost or duplicated.
- Flush and Rst simultaneous: Rst behaviour.

## Configuration
- IF_ID_BUFFER_PERF_CNT_EN defined: adds outputs StallCount (32) and FlushCount (32), reset to 0 by Rst. StallCount increments each cycle InValid & !InReady & !Rst & !Flush; FlushCount increments each cycle Flush = 1 & state != EMPTY. Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package if_id_pkg: NOP constant, occupancy state encoding (EMPTY/ONE/FULL), field bit-position constants (OPCODE_HI/LO, RS_HI/LO, etc.).
- Sub-module instr_field_decode: combinational OutInstr -> Opcode/Rs/Rt/Rd/Shamt/Funct/Imm/JAddr; reusable by later stages.

## Test plan
- Reset: Rst high 2 cycles with InValid = 1 -> OutValid 0, OutInstr 32'h0, InReady 0; after release InReady 1.
- Streaming: push PC 4,8,12 with instr 32'h8C22_0004, 32'h0043_2020, 32'h1000_FFFF, OutReady 1 -> each appears one cycle later in order; for 32'h1000_FFFF Opcode 6'h04, Imm 32'hFFFF_FFFF; for 32'h0043_2020 Rs 2, Rt 3, Rd 4, Funct 6'h20.
- Back-pressure: OutReady 0, InValid 1 for 4 cycles with PC 4,8,12,16 -> only PC 4 and 8 accepted, InReady 0 from third cycle; release OutReady -> 4 then 8 delivered, then 12 accepted.
- Simultaneous push/pop in ONE: head PC 4, push PC 8 while popping -> next cycle OutPC 8, state ONE.
- Flush in FULL with InValid 1 -> that cycle OutValid 0, InReady 0; next cycle EMPTY, offered word not present; with macro FlushCount = 1.
- Macro on: 3 cycles of InValid with state FULL and OutReady 0 -> StallCount = 3.
